// File: rtl/gpr_wb_arbiter.sv
// -----------------------------------------------------------------------------
// gpr_wb_arbiter
//
// Write-back controller for the single write port of the 32x32 general-purpose
// register file. Two requesters compete for the port:
//   - EXU: single-cycle ALU results
//   - LSU: multi-cycle load results
// The winning request is registered onto the register-file write port one
// cycle after it is accepted. An optional per-register busy scoreboard lets
// decode stall on registers that still have an outstanding load.
//
// Handshake (both requesters): a request is accepted in a cycle where
// X_valid & X_ready are both high (X_fire). A requester holds valid/rd/data
// stable until it sees ready. Ready is combinational from the two valids and
// the starvation counter only, never from rd/data. At most one fire per cycle.
//
// Arbitration: a lone valid always wins. With both valid the LSU wins, except
// after the EXU has lost two cycles in a row, when the EXU wins once.
//
// Configuration macro: WBARB_SCOREBOARD_EN
//   defined   -> busy scoreboard present, rs1_busy/rs2_busy driven from it
//   undefined -> no busy flops, rs1_busy = rs2_busy = 0, issue/query inputs
//                are ignored; arbitration and write port are unchanged
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   exu_valid/rd/data        EXU write-back request
//   exu_ready                EXU request accepted this cycle
//   lsu_valid/rd/data        LSU write-back request
//   lsu_ready                LSU request accepted this cycle
//   issue_valid, issue_rd    a load to issue_rd is issued this cycle
//   q_rs1, q_rs2             source indices queried by decode
//   rs1_busy, rs2_busy       queried register has an outstanding load
//   RegWEn                   register-file write enable
//   addr_towrite             register-file write index
//   data_towrite             register-file write data
// -----------------------------------------------------------------------------
module gpr_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              exu_valid,
    input  logic [ADDR_W-1:0] exu_rd,
    input  logic [DATA_W-1:0] exu_data,
    output logic              exu_ready,

    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              lsu_ready,

    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] q_rs1,
    input  logic [ADDR_W-1:0] q_rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,

    output logic              RegWEn,
    output logic [ADDR_W-1:0] addr_towrite,
    output logic [DATA_W-1:0] data_towrite
);

    localparam logic [1:0] STARVE_MAX = 2'd2;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic [1:0] starve_cnt_q, starve_cnt_d;
    logic       exu_priority;
    logic       exu_fire;
    logic       lsu_fire;

    // EXU has been passed over twice in a row: it takes the port this cycle.
    assign exu_priority = (starve_cnt_q == STARVE_MAX);

    assign exu_ready = exu_valid & (~lsu_valid | exu_priority);
    assign lsu_ready = lsu_valid & ~(exu_valid & exu_priority);

    assign exu_fire = exu_valid & exu_ready;
    assign lsu_fire = lsu_valid & lsu_ready;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!exu_valid || exu_fire) begin
            starve_cnt_d = 2'd0;
        end else if (starve_cnt_q != STARVE_MAX) begin
            // EXU valid but not accepted means the LSU took the port.
            starve_cnt_d = starve_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= 2'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Write stage
    // -------------------------------------------------------------------------
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        if (exu_fire) begin
            addr_d = exu_rd;
            data_d = exu_data;
        end else if (lsu_fire) begin
            addr_d = lsu_rd;
            data_d = lsu_data;
        end
        // x0 writes complete the handshake but never reach the register file.
        we_d = (exu_fire | lsu_fire) & (addr_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign RegWEn       = we_q;
    assign addr_towrite = addr_q;
    assign data_towrite = data_q;

    // -------------------------------------------------------------------------
    // Busy scoreboard
    // -------------------------------------------------------------------------
`ifdef WBARB_SCOREBOARD_EN
    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:1] busy_q, busy_d;
    logic [NREG-1:0] busy_vec;
    logic [NREG-1:0] busy_nxt;

    // Bit 0 is constant zero so x0 never reads as busy.
    assign busy_vec = {busy_q, 1'b0};

    always_comb begin
        busy_nxt = busy_vec;
        if (lsu_fire) begin
            busy_nxt[lsu_rd] = 1'b0;
        end
        // Applied after the clear: a new load to the same register supersedes
        // the one completing this cycle.
        if (issue_valid && (issue_rd != '0)) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_d = busy_nxt[NREG-1:1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy = busy_vec[q_rs1];
    assign rs2_busy = busy_vec[q_rs2];
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{issue_valid, issue_rd, q_rs1, q_rs2};

    assign rs1_busy = 1'b0;
    assign rs2_busy = 1'b0;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for gpr_wb_arbiter.
// Inputs change on the falling edge; readies and busy flags are sampled just
// after that, write-port outputs are sampled 1 ns after the rising edge.
// Each accepted cycle pushes the expected write-port contents into exp_q and
// the following rising edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_gpr_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int WB_W   = 1 + ADDR_W + DATA_W;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // DUT
    // -------------------------------------------------------------------------
    logic              exu_valid = 1'b0;
    logic [ADDR_W-1:0] exu_rd    = '0;
    logic [DATA_W-1:0] exu_data  = '0;
    logic              exu_ready;
    logic              lsu_valid = 1'b0;
    logic [ADDR_W-1:0] lsu_rd    = '0;
    logic [DATA_W-1:0] lsu_data  = '0;
    logic              lsu_ready;
    logic              issue_valid = 1'b0;
    logic [ADDR_W-1:0] issue_rd    = '0;
    logic [ADDR_W-1:0] q_rs1       = '0;
    logic [ADDR_W-1:0] q_rs2       = '0;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              RegWEn;
    logic [ADDR_W-1:0] addr_towrite;
    logic [DATA_W-1:0] data_towrite;

    gpr_wb_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .exu_valid   (exu_valid),
        .exu_rd      (exu_rd),
        .exu_data    (exu_data),
        .exu_ready   (exu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .q_rs1       (q_rs1),
        .q_rs2       (q_rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .RegWEn      (RegWEn),
        .addr_towrite(addr_towrite),
        .data_towrite(data_towrite)
    );

    // -------------------------------------------------------------------------
    // Scoreboard and reference state
    // -------------------------------------------------------------------------
    logic [WB_W-1:0]   exp_q[$];
    int                tests_run    = 0;
    int                tests_failed = 0;

    logic [1:0]        m_starve;
    logic [31:0]       m_busy;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    int                last_grant;   // 0 none, 1 EXU, 2 LSU (observed from DUT)

    task automatic check_val(input string tag, input logic [63:0] act,
                             input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic exp_busy(input logic [ADDR_W-1:0] idx);
`ifdef WBARB_SCOREBOARD_EN
        return m_busy[idx];
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_starve = 2'd0;
        m_busy   = '0;
        m_addr   = '0;
        m_data   = '0;
        exp_q.delete();
    endtask

    // One clock cycle. Called right after a falling edge with inputs set.
    task automatic step();
        logic            e_rdy, l_rdy;
        logic            we;
        logic [WB_W-1:0] w;
        #1;
        e_rdy = exu_valid && (!lsu_valid || (m_starve == 2'd2));
        l_rdy = lsu_valid && !(exu_valid && (m_starve == 2'd2));
        check_val("exu_ready", exu_ready, e_rdy);
        check_val("lsu_ready", lsu_ready, l_rdy);
        check_val("rs1_busy", rs1_busy, exp_busy(q_rs1));
        check_val("rs2_busy", rs2_busy, exp_busy(q_rs2));
        last_grant = (exu_valid && exu_ready) ? 1 : (lsu_valid && lsu_ready) ? 2 : 0;

        we = 1'b0;
        if (e_rdy) begin
            m_addr = exu_rd;
            m_data = exu_data;
            we     = (exu_rd != '0);
        end else if (l_rdy) begin
            m_addr = lsu_rd;
            m_data = lsu_data;
            we     = (lsu_rd != '0);
        end
        exp_q.push_back({we, m_addr, m_data});

        if (!exu_valid || e_rdy) m_starve = 2'd0;
        else if (m_starve != 2'd2) m_starve = m_starve + 2'd1;

        if (l_rdy) m_busy[lsu_rd] = 1'b0;
        if (issue_valid && issue_rd != '0) m_busy[issue_rd] = 1'b1;

        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val("exp_q_empty", 64'd1, 64'd0);
        end else begin
            w = exp_q.pop_front();
            check_val("RegWEn", RegWEn, w[WB_W-1]);
            check_val("addr_towrite", addr_towrite, w[WB_W-2:DATA_W]);
            check_val("data_towrite", data_towrite, w[DATA_W-1:0]);
        end
        @(negedge clk);
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic idle();
        exu_valid   = 1'b0;
        lsu_valid   = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic drive_exu(input logic v, input logic [ADDR_W-1:0] rd,
                             input logic [DATA_W-1:0] d);
        exu_valid = v;
        exu_rd    = rd;
        exu_data  = d;
    endtask

    task automatic drive_lsu(input logic v, input logic [ADDR_W-1:0] rd,
                             input logic [DATA_W-1:0] d);
        lsu_valid = v;
        lsu_rd    = rd;
        lsu_data  = d;
    endtask

    task automatic drive_issue(input logic v, input logic [ADDR_W-1:0] rd);
        issue_valid = v;
        issue_rd    = rd;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    int exp_grants[6];

    initial begin
        model_reset();
        last_grant = 0;
        exp_grants[0] = 2; exp_grants[1] = 2; exp_grants[2] = 1;
        exp_grants[3] = 2; exp_grants[4] = 2; exp_grants[5] = 1;

        // Reset with both requesters valid: nothing is written.
        drive_exu(1'b1, 5'd3, 32'h1111_0003);
        drive_lsu(1'b1, 5'd4, 32'h2222_0004);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_val("RegWEn_in_reset", RegWEn, 1'b0);
            check_val("addr_in_reset", addr_towrite, '0);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // First cycle out of reset: LSU wins.
        #1;
        check_val("post_rst_lsu_ready", lsu_ready, 1'b1);
        check_val("post_rst_exu_ready", exu_ready, 1'b0);
        #1;
        @(negedge clk);
        step();   // shared cycle: LSU to x4 (re-aligns after the peeks above)
        idle();
        step();

        // EXU alone: one-cycle write pulse.
        drive_exu(1'b1, 5'd5, 32'hDEAD_BEEF);
        step();
        idle();
        check_val("exu_wr_en", RegWEn, 1'b1);
        check_val("exu_wr_addr", addr_towrite, 5'd5);
        check_val("exu_wr_data", data_towrite, 32'hDEAD_BEEF);
        step();
        check_val("exu_wr_pulse_end", RegWEn, 1'b0);

        // Both valid: L, L, E, L, L, E (counter clears after the EXU grant).
        for (int i = 0; i < 6; i++) begin
            drive_exu(1'b1, 5'(10 + i), 32'hE000_0000 + i);
            drive_lsu(1'b1, 5'(20 + i), 32'hA000_0000 + i);
            step();
            check_val($sformatf("grant_%0d", i), last_grant, exp_grants[i]);
        end
        idle();
        step();

        // EXU write to x0: accepted, never written.
        drive_exu(1'b1, 5'd0, 32'h0000_1234);
        step();
        check_val("x0_accepted", last_grant, 1);
        check_val("x0_no_write", RegWEn, 1'b0);
        idle();
        step();

        // Scoreboard: issue x7, then the load to x7 completes.
        q_rs1 = 5'd7;
        drive_issue(1'b1, 5'd7);
        step();
        drive_issue(1'b0, 5'd0);
        #1;
        check_val("busy_after_issue", rs1_busy, exp_busy(5'd7));
`ifdef WBARB_SCOREBOARD_EN
        check_val("busy_x7_set", rs1_busy, 1'b1);
`else
        check_val("busy_x7_off", rs1_busy, 1'b0);
`endif
        drive_lsu(1'b1, 5'd7, 32'h0000_0777);
        step();
        idle();
        check_val("busy_x7_cleared", rs1_busy, 1'b0);
        check_val("load_x7_wr_en", RegWEn, 1'b1);
        check_val("load_x7_wr_addr", addr_towrite, 5'd7);

        // Issue x7 while another load to x7 completes: set wins.
        drive_issue(1'b1, 5'd7);
        step();
        drive_lsu(1'b1, 5'd7, 32'h0000_0778);
        step();
        idle();
        #1;
`ifdef WBARB_SCOREBOARD_EN
        check_val("busy_set_wins", rs1_busy, 1'b1);
`else
        check_val("busy_set_wins_off", rs1_busy, 1'b0);
`endif
        step();

        // Async reset mid-write: RegWEn falls with no clock edge.
        drive_exu(1'b1, 5'd9, 32'h9999_0009);
        step();
        idle();
        check_val("pre_async_wr_en", RegWEn, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check_val("async_rst_wr_en", RegWEn, 1'b0);
        check_val("async_rst_addr", addr_towrite, '0);
        check_val("async_rst_data", data_towrite, '0);
        check_val("async_rst_busy", rs1_busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step();

        // Random traffic; requesters hold until accepted.
        for (int i = 0; i < 300; i++) begin
            if (!exu_valid || last_grant == 1) begin
                drive_exu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            end
            if (!lsu_valid || last_grant == 2) begin
                drive_lsu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            end
            drive_issue(1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
            q_rs1 = 5'($urandom_range(0, 31));
            q_rs2 = 5'($urandom_range(0, 31));
            step();
        end
        idle();
        step();

        check_val("exp_q_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gpr_wb_arbiter.md
# gpr_wb_arbiter

Write-back controller for the single write port of the 32×32 general-purpose register file. Arbitrates between the EXU (single-cycle ALU results) and the LSU (multi-cycle load results) with valid/ready handshakes. Registers the winning write onto the register-file write port and keeps a per-register busy scoreboard so the decode stage can stall on outstanding loads. Sits between EXU/LSU and the register file in the NPC core.

## Interface
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register index width (32 registers)

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted when 0)
- `exu_valid`  in  1  EXU has a write-back request
- `exu_rd`  in  ADDR_W  EXU destination index
- `exu_data`  in  DATA_W  EXU result
- `exu_ready`  out  1  EXU request accepted this cycle
- `lsu_valid`  in  1  LSU has a write-back request
- `lsu_rd`  in  ADDR_W  LSU destination index
- `lsu_data`  in  DATA_W  load result
- `lsu_ready`  out  1  LSU request accepted this cycle
- `issue_valid`  in  1  a load is issued this cycle
- `issue_rd`  in  ADDR_W  destination of the issued load
- `q_rs1`, `q_rs2`  in  ADDR_W  source indices queried by decode
- `rs1_busy`, `rs2_busy`  out  1  queried register has an outstanding load
- `RegWEn`  out  1  register-file write enable
- `addr_towrite`  out  ADDR_W  register-file write index
- `data_towrite`  out  DATA_W  register-file write data

## Operation
- Accept: `X_fire = X_valid & X_ready`. At most one fire per cycle.
- Arbitration (combinational ready):
  - only one valid → it gets ready;
  - both valid → LSU wins, unless `starve_cnt == 2`, in which case EXU wins.
- `starve_cnt` (2 bits):
  - +1 on each cycle EXU is valid and loses;
  - cleared on `exu_fire` or whenever `exu_valid` is 0;
  - saturates at 2.
- Write stage register, updated every cycle:
  - `RegWEn <= fire & (rd != 0)`;
  - `addr_towrite`/`data_towrite` load the winner's rd/data on fire, otherwise hold.
- x0 writes: the handshake completes normally, `RegWEn` stays 0, and no scoreboard clear occurs.
- Register file never backpressures; the write stage holds no pending entry beyond one cycle.
- Scoreboard `busy[31:1]`, with `busy[0]` hardwired to 0:
  - set `busy[issue_rd]` on `issue_valid & issue_rd != 0`;
  - clear `busy[lsu_rd]` on `lsu_fire`;
  - same index set and cleared in the same cycle → set wins (new load supersedes);
  - issue to an already-busy register → stays set;
  - LSU write to a non-busy register → written normally, busy unchanged.
- `rsN_busy = busy[q_rsN]`, combinational from flops. The clear is visible the cycle after `lsu_fire`, which is the same cycle `RegWEn` writes the data.

## Timing
- Reset values:
  - `RegWEn` = 0, `addr_towrite` = 0, `data_towrite` = 0;
  - `busy` all 0, `starve_cnt` = 0;
  - `exu_ready`/`lsu_ready` follow their valids combinationally; after reset each is 1 if its own valid alone is high.
- Latency: fire in cycle N → `RegWEn` high for exactly cycle N+1. Back-to-back fires produce back-to-back write pulses.
- Valid/ready: a requester holds valid/rd/data stable until its ready is seen high. Ready depends only on valids and `starve_cnt`, never on the requester's data.
- Reset asserted mid-operation: all state clears asynchronously, any in-flight write is dropped, and `RegWEn` falls immediately.

## Configuration
- `WBARB_SCOREBOARD_EN` defined: scoreboard as described.
- Undefined:
  - no busy flops;
  - `rs1_busy` = `rs2_busy` = 0;
  - `issue_valid`/`issue_rd`/`q_rs1`/`q_rs2` ignored;
  - arbitration and write port unchanged.

## Test plan
- Reset with both valids high → `RegWEn`=0 during reset; after release, LSU fires first (`lsu_ready`=1, `exu_ready`=0).
- EXU alone: rd=5, data=0xDEADBEEF in cycle N → cycle N+1 `RegWEn`=1, `addr_towrite`=5, `data_towrite`=0xDEADBEEF; `RegWEn`=0 in cycle N+2.
- LSU and EXU both valid for 4 cycles → grants L, L, E, L; `starve_cnt` returns to 0 after the EXU grant.
- EXU write rd=0, data=0x1234 → `exu_ready`=1, `RegWEn` stays 0.
- Scoreboard (macro on): issue rd=7 → next cycle `rs1_busy`=1 with `q_rs1`=7. `lsu_fire` rd=7 → cycle after, `rs1_busy`=0 and `RegWEn`=1 to x7. Issue rd=7 in the same cycle as `lsu_fire` rd=7 → busy stays 1.
- Macro off: issue rd=7 → `rs1_busy`=0 always. Async reset pulse mid-write → `RegWEn` drops without waiting for a clock edge.
